// File: rtl/set_cfg_timer.sv
// Slow-peripheral settings register with slow-access watchdog.
// Optional write lock enabled by defining SET_LOCK_EN.
module set_cfg_timer #(
   parameter int                NSLOW     = 8,
   parameter int                TW        = 4,
   parameter int                AW        = 11,
   parameter logic [NSLOW-1:0]  RST_FLAGS = 8'hBF
) (
   input  logic             CLK,
   input  logic             nPOR,
   input  logic             BACT,
   input  logic             SetCSWR,
   input  logic [AW:1]      A,
   input  logic             TickEn,
   input  logic             SlowStart,
   input  logic             SlowDone,
   output logic [NSLOW-1:0] Slow,
   output logic [TW-1:0]    SlowTimeout,
   output logic             SlowBusy,
   output logic             SlowExpire,
   output logic             Locked
);

   localparam logic [TW-1:0] CNT_ZERO = TW'(0);
   localparam logic [TW-1:0] CNT_ONE  = TW'(1);

   logic             r_wr;
   logic             r_wrq;
   logic [NSLOW-1:0] r_slow;
   logic [TW-1:0]    r_timeout;
   logic [TW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_expire;

   logic             w_locked;
   logic             w_commit;
   logic [TW-1:0]    w_cnt_nxt;
   logic             w_busy_nxt;
   logic             w_expire_nxt;
   logic             w_unused_a;

   // A single commit per bus cycle: only the first registered cycle of the select counts.
   assign w_commit   = r_wr && !r_wrq && !w_locked;
   assign w_unused_a = ^A;

`ifdef SET_LOCK_EN
   logic r_locked;

   // Sticky lock, set by a timeout write that also carries the lock bit.
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         r_locked <= 1'b0;
      end else if (w_commit && A[AW] && A[AW-1]) begin
         r_locked <= 1'b1;
      end else begin
         r_locked <= r_locked;
      end
   end

   assign w_locked = r_locked;
`else
   assign w_locked = 1'b0;
`endif

   // Write detect and settings registers.
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         r_wr      <= 1'b0;
         r_wrq     <= 1'b0;
         r_slow    <= RST_FLAGS;
         r_timeout <= CNT_ZERO;
      end else begin
         r_wr  <= BACT && SetCSWR;
         r_wrq <= r_wr;
         if (w_commit) begin
            if (A[AW]) begin
               r_timeout <= A[TW:1];
            end else begin
               r_slow <= A[NSLOW:1];
            end
         end
      end
   end

   // Watchdog next state; start uses the timeout value held before any same-cycle commit.
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_busy_nxt   = r_busy;
      w_expire_nxt = 1'b0;
      if (SlowStart) begin
         w_cnt_nxt  = r_timeout;
         w_busy_nxt = (r_timeout != CNT_ZERO);
      end else if (SlowDone && r_busy) begin
         w_cnt_nxt  = CNT_ZERO;
         w_busy_nxt = 1'b0;
      end else if (r_busy && TickEn) begin
         w_cnt_nxt = r_cnt - CNT_ONE;
         if (r_cnt == CNT_ONE) begin
            w_busy_nxt   = 1'b0;
            w_expire_nxt = 1'b1;
         end else begin
            w_busy_nxt   = 1'b1;
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Watchdog registers.
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         r_cnt    <= CNT_ZERO;
         r_busy   <= 1'b0;
         r_expire <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_expire <= w_expire_nxt;
      end
   end

   assign Slow        = r_slow;
   assign SlowTimeout = r_timeout;
   assign SlowBusy    = r_busy;
   assign SlowExpire  = r_expire;
   assign Locked      = w_locked;

endmodule
